// File: rtl/ram_ctrl_pkg.sv
// Shared constants for the image RAM phase sequencer:
// phase encodings, FSM state codes and default widths.
package ram_ctrl_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] PH_LOAD = 2'd0;
  localparam logic [1:0] PH_PROC = 2'd1;
  localparam logic [1:0] PH_DUMP = 2'd2;
  localparam logic [1:0] PH_DONE = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t S_LOAD       = 3'd0;
  localparam state_t S_LAST_WR    = 3'd1;
  localparam state_t S_PROC_START = 3'd2;
  localparam state_t S_PROC_WAIT  = 3'd3;
  localparam state_t S_DUMP       = 3'd4;
  localparam state_t S_DONE       = 3'd5;

  typedef logic [1:0] rd_state_t;

  localparam rd_state_t R_IDLE = 2'd0;
  localparam rd_state_t R_ADDR = 2'd1;
  localparam rd_state_t R_WAIT = 2'd2;
  localparam rd_state_t R_TX   = 2'd3;

endpackage

// File: rtl/ram_phase_ctrl_if.sv
// Bus bundle between the phase sequencer and the UART,
// processor and image RAM around it.
interface ram_phase_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              proc_start;
  logic              proc_done;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              select;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic              uart_wr_en;
  logic [1:0]        phase;
  logic              done;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  proc_done,
    input  ram_rdata,
    input  tx_ready,
    output proc_start,
    output tx_data,
    output tx_valid,
    output select,
    output uart_addr,
    output uart_wdata,
    output uart_wr_en,
    output phase,
    output done
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output proc_done,
    output ram_rdata,
    output tx_ready,
    input  proc_start,
    input  tx_data,
    input  tx_valid,
    input  select,
    input  uart_addr,
    input  uart_wdata,
    input  uart_wr_en,
    input  phase,
    input  done
  );

endinterface

// File: rtl/ram_phase_ctrl_dump_reader.sv
// Readback loop: present address, wait for the registered
// RAM, then offer the byte to the transmitter until taken.
module dump_reader
  import ram_ctrl_pkg::*;
#(
  parameter int              ADDR_W = ADDR_W_DEF,
  parameter int              DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] LAST = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] rdata,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  output logic              step,
  output logic              finished
);

  rd_state_t         st;
  logic [ADDR_W-1:0] cnt;
  logic              fire;
  logic              at_last;

  assign fire     = (st == R_TX) & tx_ready;
  assign at_last  = (cnt == LAST);
  assign step     = fire & ~at_last;
  assign finished = fire & at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= R_IDLE;
      cnt      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      unique case (1'b1)
        (st == R_IDLE): begin
          if (start) begin
            cnt <= '0;
            st  <= R_ADDR;
          end
        end
        (st == R_ADDR): begin
          st <= R_WAIT;
        end
        (st == R_WAIT): begin
          tx_data  <= rdata;
          tx_valid <= 1'b1;
          st       <= R_TX;
        end
        (st == R_TX): begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            // counter parks on LAST instead of wrapping
            if (at_last) begin
              st <= R_IDLE;
            end else begin
              cnt <= cnt + ADDR_W'(1);
              st  <= R_ADDR;
            end
          end
        end
        default: st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ram_phase_ctrl.sv
// Frame sequencer: UART load into RAM, processor handoff,
// then UART readback of the processed image.
module ram_phase_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] IN_LAST  = 16'hFFFF,
  parameter logic [ADDR_W-1:0] OUT_LAST = 16'h3FFF
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_phase_ctrl_if.master bus
);

  state_t            st;
  logic [ADDR_W-1:0] load_cnt;
  logic              rx_take;
  logic              rd_start;
  logic              rd_step;
  logic              rd_fin;

  assign rx_take  = bus.rx_valid
                  & ((st == S_LOAD) | (st == S_DONE));
  assign rd_start = (st == S_PROC_WAIT) & bus.proc_done;

  dump_reader #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LAST   (OUT_LAST)
  ) u_rd (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (rd_start),
    .rdata    (bus.ram_rdata),
    .tx_ready (bus.tx_ready),
    .tx_valid (bus.tx_valid),
    .tx_data  (bus.tx_data),
    .step     (rd_step),
    .finished (rd_fin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= S_LOAD;
      load_cnt       <= '0;
      bus.select     <= 1'b0;
      bus.uart_wr_en <= 1'b0;
      bus.uart_addr  <= '0;
      bus.uart_wdata <= '0;
      bus.proc_start <= 1'b0;
      bus.phase      <= PH_LOAD;
      bus.done       <= 1'b0;
    end else begin
      bus.uart_wr_en <= 1'b0;
      bus.proc_start <= 1'b0;
      unique case (1'b1)
        rx_take: begin
          bus.uart_wr_en <= 1'b1;
          bus.uart_addr  <= load_cnt;
          bus.uart_wdata <= bus.rx_data;
          bus.done       <= 1'b0;
          bus.phase      <= PH_LOAD;
          if (load_cnt == IN_LAST) begin
            load_cnt <= '0;
            st       <= S_LAST_WR;
          end else begin
            load_cnt <= load_cnt + ADDR_W'(1);
            st       <= S_LOAD;
          end
        end
        // select flips only once the last write is done
        (st == S_LAST_WR): begin
          bus.select     <= 1'b1;
          bus.proc_start <= 1'b1;
          bus.phase      <= PH_PROC;
          st             <= S_PROC_START;
        end
        (st == S_PROC_START): begin
          st <= S_PROC_WAIT;
        end
        rd_start: begin
          bus.select    <= 1'b0;
          bus.uart_addr <= '0;
          bus.phase     <= PH_DUMP;
          st            <= S_DUMP;
        end
        rd_step: begin
          bus.uart_addr <= bus.uart_addr + ADDR_W'(1);
        end
        rd_fin: begin
          bus.done  <= 1'b1;
          bus.phase <= PH_DONE;
          st        <= S_DONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_phase_ctrl.sv
// Bench for ram_phase_ctrl: small-frame scoreboard plus
// a full-size default-parameter load.
module tb_ram_phase_ctrl;

  localparam int          AW = 16;
  localparam int          DW = 8;
  localparam logic [15:0] SIN  = 16'd15;
  localparam logic [15:0] SOUT = 16'd3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  ram_phase_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) s ();
  ram_phase_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b ();

  ram_phase_ctrl #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .IN_LAST  (SIN),
    .OUT_LAST (SOUT)
  ) u_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s.master)
  );

  ram_phase_ctrl u_b (
    .clk   (clk),
    .rst_n (rst_b),
    .bus   (b.master)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endfunction

  // image RAM: processor writes 0xA0+addr when started
  logic [7:0] ram [0:65535];

  always @(posedge clk) begin
    if (s.proc_start) begin
      for (int a = 0; a < 4; a++) ram[a] <= 8'(8'hA0 + a);
    end else if (!s.select && s.uart_wr_en) begin
      ram[s.uart_addr] <= s.uart_wdata;
    end
    s.ram_rdata <= ram[s.uart_addr];
  end

  int          m_phase, m_cnt, m_dcnt, m_txin;
  logic        m_wr_v, m_pstart, m_last, nwr, npst;
  logic [15:0] m_wa;
  logic [7:0]  m_wd;
  logic [7:0]  tx_log [$];
  int          ps_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ctl", {s.select, s.uart_wr_en, s.tx_valid,
                      s.proc_start, s.done, s.phase}, 0);
      chk("rst_addr", s.uart_addr, 0);
      chk("rst_data", {s.uart_wdata, s.tx_data}, 0);
      m_phase = 0; m_cnt = 0; m_dcnt = 0; m_txin = 0;
      m_wr_v = 0; m_pstart = 0; m_last = 0;
    end else begin
      chk("phase", s.phase, m_phase);
      chk("select", s.select, m_phase == 1);
      chk("done", s.done, m_phase == 3);
      chk("wr_en", s.uart_wr_en, m_wr_v);
      if (m_wr_v) begin
        chk("wr_addr", s.uart_addr, m_wa);
        chk("wr_data", s.uart_wdata, m_wd);
      end
      chk("proc_start", s.proc_start, m_pstart);
      chk("tx_valid", s.tx_valid, m_phase == 2 && m_txin == 0);
      if (m_phase == 2 && m_txin == 0)
        chk("tx_data", s.tx_data, 8'(8'hA0 + m_dcnt));
      if (m_phase == 2 && m_txin == 2)
        chk("rd_addr", s.uart_addr, m_dcnt);
      if (s.proc_start) ps_cnt++;
      if (s.tx_valid && s.tx_ready) tx_log.push_back(s.tx_data);
      nwr = 0;
      npst = 0;
      if (m_last) begin
        m_last = 0;
        m_phase = 1;
        npst = 1;
      end else if (m_phase == 0 || m_phase == 3) begin
        if (s.rx_valid) begin
          nwr = 1;
          m_wa = 16'(m_cnt);
          m_wd = s.rx_data;
          m_phase = 0;
          if (m_cnt == int'(SIN)) begin
            m_cnt = 0;
            m_last = 1;
          end else m_cnt++;
        end
      end else if (m_phase == 1) begin
        if (!m_pstart && s.proc_done) begin
          m_phase = 2;
          m_dcnt = 0;
          m_txin = 2;
        end
      end else begin
        if (m_txin > 0) m_txin--;
        else if (s.tx_ready) begin
          if (m_dcnt == int'(SOUT)) m_phase = 3;
          else begin
            m_dcnt++;
            m_txin = 2;
          end
        end
      end
      m_wr_v = nwr;
      m_pstart = npst;
    end
  end

  int          b_exp = 0;
  int          b_wr_cnt = 0;
  int          b_ps_cnt = 0;
  logic [15:0] b_last_wa = '0;

  always @(negedge clk) begin
    if (rst_b) begin
      if (b.uart_wr_en) begin
        chk("big_wr", {b.select, b.uart_addr, b.uart_wdata},
            {1'b0, 16'(b_exp), 8'(b_exp)});
        chk("big_nowrap", b_exp < 65536, 1);
        b_exp++;
        b_wr_cnt++;
        b_last_wa = b.uart_addr;
      end
      if (b.proc_start) b_ps_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    s.rx_valid = 1'b1;
    s.rx_data  = d;
    tick();
  endtask

  task automatic wait_tx(input string n);
    for (int k = 0; k < 10 && !s.tx_valid; k++) tick();
    chk(n, s.tx_valid, 1);
  endtask

  task automatic wait_done(input string n);
    for (int k = 0; k < 60 && !s.done; k++) tick();
    chk(n, s.done, 1);
  endtask

  initial begin
    s.rx_valid = 0; s.rx_data = 0; s.proc_done = 0;
    s.tx_ready = 0;
    b.rx_valid = 0; b.rx_data = 0; b.proc_done = 0;
    b.tx_ready = 0; b.ram_rdata = 0;
    repeat (3) tick();
    chk("rst_phase_lit", s.phase, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i));
    s.rx_valid = 0;
    chk("last_wr_lit", {s.uart_wr_en, s.uart_addr}, 17'h1000F);
    tick();
    chk("pstart_lit", {s.proc_start, s.select, s.uart_wr_en}, 3'b110);
    s.rx_valid = 1; s.rx_data = 8'hEE;
    repeat (3) tick();
    s.rx_valid = 0;
    repeat (7) tick();
    s.proc_done = 1;
    tick();
    s.proc_done = 0;
    chk("sel_after_done", s.select, 0);
    chk("phase_dump_lit", s.phase, 2);
    wait_tx("tx_first_timeout");
    repeat (5) tick();
    chk("tx_hold_lit", {s.tx_valid, s.tx_data}, 9'h1A0);
    s.tx_ready = 1;
    wait_done("done_timeout1");
    chk("tx_count1", tx_log.size(), 4);
    for (int i = 0; i < tx_log.size(); i++)
      chk("tx_byte_lit", tx_log[i], 8'(8'hA0 + i));
    chk("done_lit", {s.done, s.phase}, 3'b111);
    s.tx_ready = 0;
    tx_log.delete();
    send(8'h55);
    s.rx_valid = 0;
    chk("newframe_lit", {s.uart_wr_en, s.uart_addr, s.uart_wdata},
        {1'b1, 16'h0000, 8'h55});
    chk("newframe_ph", {s.done, s.phase}, 0);
    s.proc_done = 1;
    s.tx_ready = 1;
    for (int i = 1; i < 16; i++) send(8'(i));
    s.rx_valid = 0;
    wait_done("done_timeout2");
    chk("tx_count2", tx_log.size(), 4);
    chk("ps_cnt_lit", ps_cnt, 2);
    s.proc_done = 0;
    s.tx_ready = 0;
    repeat (2) tick();
    chk("done_stays", s.phase, 3);
    for (int i = 0; i < 8; i++) send(8'(i));
    s.rx_valid = 0;
    chk("mid_addr7_lit", s.uart_addr, 7);
    rst_n = 1'b0;
    #1;
    chk("mid_load_rst", {s.uart_wr_en, s.select, s.phase,
                         s.uart_addr}, 0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h30 + i));
      if (i == 0)
        chk("restart_addr0", {s.uart_wr_en, s.uart_addr}, 17'h10000);
    end
    s.rx_valid = 0;
    repeat (4) tick();
    s.proc_done = 1;
    tick();
    s.proc_done = 0;
    s.tx_ready = 1;
    tx_log.delete();
    for (int k = 0; k < 30 && tx_log.size() < 2; k++) tick();
    chk("dump_two_bytes", tx_log.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("mid_dump_rst", {s.tx_valid, s.phase, s.done, s.select}, 0);
    s.tx_ready = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst_ph", s.phase, 0);
    rst_b = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      b.rx_valid = 1;
      b.rx_data  = 8'(i);
      tick();
    end
    b.rx_valid = 0;
    tick();
    chk("big_wr_cnt", b_wr_cnt, 65536);
    chk("big_last_addr", b_last_wa, 16'hFFFF);
    chk("big_pstart_once", b_ps_cnt, 1);
    chk("big_phase_sel", {b.phase, b.select}, 3'b011);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
